// File: rtl/router_output_arbiter_if.sv
// Request and output-channel bundle for the router output arbiter.
// The slave side belongs to the arbiter; the master side drives requests.
interface router_output_arbiter_if #(
  parameter int NUM_REQ = 5,
  parameter int DATA_W  = 64
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_vc;
  logic [NUM_REQ-1:0]        req_tail;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      ch_blocked;
  logic [NUM_REQ-1:0]        grant;
  logic                      ch_valid;
  logic                      ch_vc;
  logic [DATA_W-1:0]         ch_data;

  modport master (
    output req, req_vc, req_tail, req_data,
    output ch_blocked,
    input  grant, ch_valid, ch_vc, ch_data
  );

  modport slave (
    input  req, req_vc, req_tail, req_data,
    input  ch_blocked,
    output grant, ch_valid, ch_vc, ch_data
  );
endinterface

// File: rtl/router_output_arbiter.sv
// Wormhole round-robin arbiter for one router output channel.
// Two VCs alternate by polarity, each with its own pointer and lock.
module router_output_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int DATA_W  = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic polarity,
  router_output_arbiter_if.slave arb
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [PTR_W:0] NREQ = (PTR_W+1)'(NUM_REQ);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [1:0]            lock_q;
  logic [1:0][PTR_W-1:0] ptr_q;
  logic [1:0][PTR_W-1:0] own_q;

  logic                  ch_valid_q;
  logic                  ch_vc_q;
  logic [DATA_W-1:0]     ch_data_q;

  logic                  v;
  logic [NUM_REQ-1:0]    elig;
  logic [PTR_W-1:0]      ptr_v;
  logic [PTR_W-1:0]      own_v;
  logic                  lock_v;
  logic [PTR_W-1:0]      win;
  logic                  hit;
  logic [PTR_W:0]        sum;
  logic [PTR_W-1:0]      idx;
  logic                  tail_w;
  logic [PTR_W-1:0]      nxt;
  logic [DATA_W-1:0]     win_data;

  assign v      = polarity;
  assign elig   = arb.req & ~(arb.req_vc ^ {NUM_REQ{v}});
  assign ptr_v  = ptr_q[v];
  assign own_v  = own_q[v];
  assign lock_v = lock_q[v];

  // Descending scan so the last hit is the first port at/after ptr.
  always_comb begin
    hit = 1'b0;
    win = '0;
    sum = '0;
    idx = '0;
    if (lock_v == LOCKED) begin
      hit = elig[own_v];
      win = own_v;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        sum = {1'b0, ptr_v} + (PTR_W+1)'(k);
        if (sum >= NREQ) sum = sum - NREQ;
        idx = sum[PTR_W-1:0];
        if (elig[idx]) begin
          hit = 1'b1;
          win = idx;
        end
      end
    end
    if (!reset || arb.ch_blocked) hit = 1'b0;
  end

  assign tail_w   = arb.req_tail[win];
  assign nxt      = (win == LAST) ? '0 : win + PTR_W'(1);
  assign win_data = arb.req_data[int'(win)*DATA_W +: DATA_W];

  assign arb.grant    = hit ? (NUM_REQ'(1) << win) : '0;
  assign arb.ch_valid = ch_valid_q;
  assign arb.ch_vc    = ch_vc_q;
  assign arb.ch_data  = ch_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_valid_q <= 1'b0;
      ch_vc_q    <= 1'b0;
      ch_data_q  <= '0;
      ptr_q      <= '0;
      own_q      <= '0;
      lock_q     <= {IDLE, IDLE};
    end else begin
      ch_valid_q <= hit;
      if (hit) begin
        ch_data_q <= win_data;
        ch_vc_q   <= v;
        if (tail_w) begin
          lock_q[v] <= IDLE;
          ptr_q[v]  <= nxt;
        end else begin
          lock_q[v] <= LOCKED;
          own_q[v]  <= win;
        end
      end
    end
  end
endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter.
// Inputs change 1ns after posedge; polarity flips every cycle.
module tb_router_output_arbiter;
  localparam int N = 5;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset;
  logic pol;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  router_output_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  router_output_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .polarity (pol),
    .arb      (bus)
  );

  task automatic put(input int p, input logic vc,
                     input logic tl, input logic [W-1:0] d);
    bus.req[p]          = 1'b1;
    bus.req_vc[p]       = vc;
    bus.req_tail[p]     = tl;
    bus.req_data[p*W +: W] = d;
  endtask

  task automatic drop(input int p);
    bus.req[p] = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pol = ~pol;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    pol = 1'b0;
    bus.req = '0;
    bus.req_vc = '0;
    bus.req_tail = '0;
    bus.req_data = '0;
    bus.ch_blocked = 1'b0;
    put(0, 1'b0, 1'b1, 64'h11);
    #2;
    n_chk++; if (bus.grant !== 5'b0) $display("FAIL rst_grant got=%b want=%b", bus.grant, 5'b0); else n_pass++;
    n_chk++; if (bus.ch_valid !== 1'b0) $display("FAIL rst_valid got=%b want=0", bus.ch_valid); else n_pass++;
    n_chk++; if (bus.ch_data !== 64'h0) $display("FAIL rst_data got=%h want=0", bus.ch_data); else n_pass++;
    n_chk++; if (bus.ch_vc !== 1'b0) $display("FAIL rst_vc got=%b want=0", bus.ch_vc); else n_pass++;
    drop(0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    pol = 1'b0;
  endtask

  task automatic test_single();
    put(2, 1'b0, 1'b1, 64'hfA50);
    #1;
    n_chk++; if (bus.grant !== 5'b00100) $display("FAIL single_grant got=%b want=%b", bus.grant, 5'b00100); else n_pass++;
    step();
    drop(2);
    n_chk++; if (bus.ch_valid !== 1'b1) $display("FAIL single_valid got=%b want=1", bus.ch_valid); else n_pass++;
    n_chk++; if (bus.ch_vc !== 1'b0) $display("FAIL single_vc got=%b want=0", bus.ch_vc); else n_pass++;
    n_chk++; if (bus.ch_data !== 64'hfA50) $display("FAIL single_data got=%h want=fa50", bus.ch_data); else n_pass++;
    put(0, 1'b0, 1'b1, 64'h0A);
    put(3, 1'b0, 1'b1, 64'h3A);
    #1;
    n_chk++; if (bus.grant !== 5'b0) $display("FAIL odd_idle_grant got=%b want=0", bus.grant); else n_pass++;
    step();
    n_chk++; if (bus.ch_valid !== 1'b0) $display("FAIL odd_idle_valid got=%b want=0", bus.ch_valid); else n_pass++;
    #1;
    n_chk++; if (bus.grant !== 5'b01000) $display("FAIL ptr0_is_3 got=%b want=%b", bus.grant, 5'b01000); else n_pass++;
    step();
    drop(3);
    n_chk++; if (bus.ch_data !== 64'h3A) $display("FAIL ptr0_data got=%h want=3a", bus.ch_data); else n_pass++;
    step();
    #1;
    n_chk++; if (bus.grant !== 5'b00001) $display("FAIL ptr0_wrap got=%b want=%b", bus.grant, 5'b00001); else n_pass++;
    step();
    drop(0);
    n_chk++; if (bus.ch_data !== 64'h0A) $display("FAIL wrap_data got=%h want=0a", bus.ch_data); else n_pass++;
  endtask

  task automatic test_rr_vc1();
    int exp_p[6] = '{0, 1, 4, 0, 1, 4};
    int j = 0;
    logic g;
    logic [N-1:0] eg;
    put(0, 1'b1, 1'b1, 64'h100);
    put(1, 1'b1, 1'b1, 64'h101);
    put(4, 1'b1, 1'b1, 64'h104);
    for (int k = 0; k < 12; k++) begin
      #1;
      g = pol;
      eg = g ? (N'(1) << exp_p[j]) : '0;
      n_chk++; if (bus.grant !== eg) $display("FAIL rr_grant[%0d] got=%b want=%b", k, bus.grant, eg); else n_pass++;
      step();
      n_chk++; if (bus.ch_valid !== g) $display("FAIL rr_valid[%0d] got=%b want=%b", k, bus.ch_valid, g); else n_pass++;
      if (g) begin
        n_chk++; if (bus.ch_data !== 64'h100 + 64'(exp_p[j])) $display("FAIL rr_data[%0d] got=%h want=%h", k, bus.ch_data, 64'h100 + 64'(exp_p[j])); else n_pass++;
        j++;
      end
    end
    drop(0);
    drop(1);
    drop(4);
  endtask

  task automatic test_lock();
    logic [W-1:0] f[3] = '{64'h6840, 64'hffff, 64'hc7d4};
    put(3, 1'b0, 1'b0, f[0]);
    put(0, 1'b0, 1'b1, 64'hAAAA);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (bus.grant !== 5'b0) $display("FAIL lock_odd[%0d] got=%b want=0", k, bus.grant); else n_pass++;
      step();
      #1;
      n_chk++; if (bus.grant !== 5'b01000) $display("FAIL lock_grant[%0d] got=%b want=%b", k, bus.grant, 5'b01000); else n_pass++;
      step();
      n_chk++; if (bus.ch_data !== f[k]) $display("FAIL lock_data[%0d] got=%h want=%h", k, bus.ch_data, f[k]); else n_pass++;
      if (k < 2) put(3, 1'b0, k == 1, f[k+1]);
      else drop(3);
    end
    step();
    #1;
    n_chk++; if (bus.grant !== 5'b00001) $display("FAIL lock_after got=%b want=%b", bus.grant, 5'b00001); else n_pass++;
    step();
    drop(0);
    n_chk++; if (bus.ch_data !== 64'hAAAA) $display("FAIL lock_after_data got=%h want=aaaa", bus.ch_data); else n_pass++;
  endtask

  task automatic test_blocked();
    step();
    put(1, 1'b0, 1'b0, 64'hB1);
    put(0, 1'b0, 1'b1, 64'h0A0);
    #1;
    n_chk++; if (bus.grant !== 5'b00010) $display("FAIL ptr0_is_1 got=%b want=%b", bus.grant, 5'b00010); else n_pass++;
    step();
    n_chk++; if (bus.ch_data !== 64'hB1) $display("FAIL blk_head got=%h want=b1", bus.ch_data); else n_pass++;
    put(1, 1'b0, 1'b0, 64'hB2);
    step();
    for (int k = 0; k < 3; k++) begin
      bus.ch_blocked = 1'b1;
      #1;
      n_chk++; if (bus.grant !== 5'b0) $display("FAIL blk_grant[%0d] got=%b want=0", k, bus.grant); else n_pass++;
      step();
      n_chk++; if (bus.ch_valid !== 1'b0) $display("FAIL blk_valid[%0d] got=%b want=0", k, bus.ch_valid); else n_pass++;
      bus.ch_blocked = 1'b0;
      step();
    end
    #1;
    n_chk++; if (bus.grant !== 5'b00010) $display("FAIL blk_resume got=%b want=%b", bus.grant, 5'b00010); else n_pass++;
    step();
    n_chk++; if (bus.ch_data !== 64'hB2) $display("FAIL blk_b2 got=%h want=b2", bus.ch_data); else n_pass++;
    put(1, 1'b0, 1'b1, 64'hB3);
    step();
    #1;
    n_chk++; if (bus.grant !== 5'b00010) $display("FAIL blk_tail got=%b want=%b", bus.grant, 5'b00010); else n_pass++;
    step();
    n_chk++; if (bus.ch_data !== 64'hB3) $display("FAIL blk_b3 got=%h want=b3", bus.ch_data); else n_pass++;
    drop(1);
    step();
    #1;
    n_chk++; if (bus.grant !== 5'b00001) $display("FAIL blk_next got=%b want=%b", bus.grant, 5'b00001); else n_pass++;
    step();
    drop(0);
  endtask

  task automatic test_concurrent();
    logic [W-1:0] p1[3] = '{64'hC10, 64'hC11, 64'hC12};
    logic [W-1:0] p2[3] = '{64'hD20, 64'hD21, 64'hD22};
    step();
    put(1, 1'b0, 1'b0, p1[0]);
    put(2, 1'b1, 1'b0, p2[0]);
    put(3, 1'b1, 1'b1, 64'hE3);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++; if (bus.grant !== 5'b00010) $display("FAIL cc_g0[%0d] got=%b want=%b", k, bus.grant, 5'b00010); else n_pass++;
      step();
      n_chk++; if ({bus.ch_vc, bus.ch_data} !== {1'b0, p1[k]}) $display("FAIL cc_d0[%0d] got=%b/%h want=0/%h", k, bus.ch_vc, bus.ch_data, p1[k]); else n_pass++;
      if (k < 2) put(1, 1'b0, k == 1, p1[k+1]);
      else drop(1);
      #1;
      n_chk++; if (bus.grant !== 5'b00100) $display("FAIL cc_g1[%0d] got=%b want=%b", k, bus.grant, 5'b00100); else n_pass++;
      step();
      n_chk++; if ({bus.ch_vc, bus.ch_data} !== {1'b1, p2[k]}) $display("FAIL cc_d1[%0d] got=%b/%h want=1/%h", k, bus.ch_vc, bus.ch_data, p2[k]); else n_pass++;
      if (k < 2) put(2, 1'b1, k == 1, p2[k+1]);
      else drop(2);
    end
    #1;
    n_chk++; if (bus.grant !== 5'b0) $display("FAIL cc_even_idle got=%b want=0", bus.grant); else n_pass++;
    step();
    #1;
    n_chk++; if (bus.grant !== 5'b01000) $display("FAIL cc_vc1_next got=%b want=%b", bus.grant, 5'b01000); else n_pass++;
    step();
    n_chk++; if ({bus.ch_vc, bus.ch_data} !== {1'b1, 64'hE3}) $display("FAIL cc_e3 got=%b/%h want=1/e3", bus.ch_vc, bus.ch_data); else n_pass++;
    drop(3);
  endtask

  task automatic test_async_reset();
    put(4, 1'b0, 1'b0, 64'hD4);
    #1;
    n_chk++; if (bus.grant !== 5'b10000) $display("FAIL ar_head got=%b want=%b", bus.grant, 5'b10000); else n_pass++;
    step();
    n_chk++; if (bus.ch_data !== 64'hD4) $display("FAIL ar_d4 got=%h want=d4", bus.ch_data); else n_pass++;
    put(4, 1'b0, 1'b0, 64'hD5);
    step();
    put(2, 1'b0, 1'b1, 64'hE2);
    #1;
    n_chk++; if (bus.grant !== 5'b10000) $display("FAIL ar_locked got=%b want=%b", bus.grant, 5'b10000); else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_chk++; if (bus.ch_valid !== 1'b0) $display("FAIL ar_valid got=%b want=0", bus.ch_valid); else n_pass++;
    n_chk++; if (bus.ch_data !== 64'h0) $display("FAIL ar_data got=%h want=0", bus.ch_data); else n_pass++;
    n_chk++; if (bus.grant !== 5'b0) $display("FAIL ar_grant got=%b want=0", bus.grant); else n_pass++;
    drop(4);
    @(posedge clk);
    #1;
    reset = 1'b1;
    pol = 1'b0;
    #1;
    n_chk++; if (bus.grant !== 5'b00100) $display("FAIL ar_new_head got=%b want=%b", bus.grant, 5'b00100); else n_pass++;
    step();
    n_chk++; if ({bus.ch_valid, bus.ch_vc, bus.ch_data} !== {2'b10, 64'hE2}) $display("FAIL ar_new_data got=%b/%b/%h want=1/0/e2", bus.ch_valid, bus.ch_vc, bus.ch_data); else n_pass++;
    drop(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_vc1();
    test_lock();
    test_blocked();
    test_concurrent();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish by 100000ns");
    $fatal(1);
  end
endmodule
